btb_branch_resolver: RTL and testbench
======================================

BTB_BRANCH_RESOLVER -- requirements
Module: btb_branch_resolver

Interface
REQ-001 Parameter ENTRIES, default 16, number of direct-mapped BTB entries (power of two; index = pc[log2(ENTRIES)+1:2]).
REQ-002 Parameter TAG_W, default 32-2-log2(ENTRIES), tag width; tag = pc[31:log2(ENTRIES)+2].
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 if_pc  in  32  fetch PC for lookup.
REQ-006 if_hit  out  1  entry valid and tag matches if_pc (combinational from stored state).
REQ-007 if_pred_taken  out  1  if_hit AND stored counter bit[1].
REQ-008 if_pred_target  out  32  stored target on hit, else if_pc+4.
REQ-009 ex_valid  in  1  execute-stage control-transfer instruction present this cycle.
REQ-010 ex_is_jump  in  1  1 = JAL/JALR (always taken), 0 = conditional branch.
REQ-011 ex_pc, ex_target  in  32 each  instruction PC and computed taken target.
REQ-012 ex_func3  in  3  branch type per BTYPE codes.
REQ-013 ex_pred_taken, ex_pred_target  in  1, 32  prediction carried down the pipe from fetch.
REQ-014 carry_flag, zero_flag, negative_flag, overflow_flag  in  1 each  ALU flags of rs1 - rs2.
REQ-015 flush  out  1  registered mispredict pulse.
REQ-016 redirect_pc  out  32  registered correct next PC, valid when flush=1.
REQ-017 mispredict_count  out  32  saturating count of mispredicts.

Function
REQ-018 Outcome (combinational): jump -> taken; BEQ zero; BNE !zero; BLT negative^overflow; BGE !(negative^overflow); BLTU !carry; BGEU carry; func3 010/011 -> not taken, no table update, no flush.
REQ-019 Correct PC: taken -> ex_target; not taken -> ex_pc+4 (mod 2^32, wrap at 0xFFFFFFFC gives 0).
REQ-020 Mispredict when ex_valid and (taken != ex_pred_taken, or taken AND ex_pred_taken AND ex_pred_target != ex_target).
REQ-021 On mispredict: flush=1 and redirect_pc=correct PC on the next cycle, for exactly one cycle; otherwise flush=0 and redirect_pc holds its last value.
REQ-022 Back-to-back mispredicts on consecutive cycles produce consecutive flush pulses with each cycle's redirect_pc.
REQ-023 Counter encoding: SNT=00, WNT=01, ST=10, WT=11; predict taken iff bit[1]=1.
REQ-024 Taken transitions: SNT->WNT, WNT->WT, WT->ST, ST->ST.
REQ-025 Not-taken transitions: ST->WT, WT->WNT, WNT->SNT, SNT->SNT.
REQ-026 Hit update (ex_valid, tag match): apply transition; if taken, write target=ex_target; jump forces ST.
REQ-027 Miss, taken: allocate (replace) entry: valid=1, tag, target=ex_target, counter = ST for jump, WT for branch.
REQ-028 Miss, not taken: no table write.
REQ-029 Lookup and update to the same index in the same cycle: lookup returns pre-update contents; new contents visible next cycle.
REQ-030 mispredict_count increments by 1 per mispredict; holds at 0xFFFFFFFF.
REQ-031 ex_valid=0: no table write, no flush, no count change; flags ignored.

Reset
REQ-032 rst_n low asynchronously clears all valid bits, counters to SNT, flush=0, redirect_pc=0, mispredict_count=0; tags/targets need not reset.
REQ-033 Reset asserted mid-update discards that update; first lookup after release returns if_hit=0, if_pred_target=if_pc+4.

Verification
REQ-034 After reset, if_pc=0x100 -> if_hit=0, if_pred_taken=0, if_pred_target=0x104.
REQ-035 BEQ at 0x100, zero_flag=1, target 0x200, pred_taken=0 -> next cycle flush=1, redirect_pc=0x200, count=1; then if_pc=0x100 -> hit, taken, target 0x200 (WT).
REQ-036 Same branch resolved not-taken twice -> WT->WNT->SNT; second resolution with pred_taken=0 gives no flush; if_pred_taken=0.
REQ-037 BLTU with carry_flag=0 and BGE with negative=1, overflow=1 -> both taken; BLT with negative=1, overflow=1 -> not taken.
REQ-038 JAL at 0x40 target 0x80 pred_taken=0 -> flush, redirect 0x80, entry ST; alias PC 0x40+4*ENTRIES taken to 0x300 -> replaces entry, 0x40 then misses.
REQ-039 Assert rst_n low same cycle as a mispredicting update -> flush=0, count=0, table empty after release.

Source files
------------

// File: rtl/btb_branch_resolver_if.sv
// -----------------------------------------------------------------------------
// btb_branch_resolver_if
// Bundles the fetch-side lookup port and the execute-side resolution port of
// the branch target buffer / branch resolver.
//
//   Fetch lookup : if_pc -> if_hit, if_pred_taken, if_pred_target
//   Resolution   : ex_valid, ex_is_jump, ex_pc, ex_target, ex_func3,
//                  ex_pred_taken, ex_pred_target, ALU flags
//                  -> flush, redirect_pc, mispredict_count
//
// Handshake: there is no backpressure. ex_valid qualifies every ex_* input
// and the flags for the cycle it is high; flush is a one-cycle registered
// pulse that qualifies redirect_pc. The lookup outputs are always valid and
// depend only on if_pc and stored table state.
//
// master : pipeline side (drives PCs and resolution info)
// slave  : btb_branch_resolver
// -----------------------------------------------------------------------------
interface btb_branch_resolver_if;
   // fetch lookup
   logic [31:0] if_pc;
   logic        if_hit;
   logic        if_pred_taken;
   logic [31:0] if_pred_target;
   // execute resolution
   logic        ex_valid;
   logic        ex_is_jump;
   logic [31:0] ex_pc;
   logic [31:0] ex_target;
   logic [2:0]  ex_func3;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        carry_flag;
   logic        zero_flag;
   logic        negative_flag;
   logic        overflow_flag;
   // redirect / statistics
   logic        flush;
   logic [31:0] redirect_pc;
   logic [31:0] mispredict_count;

   modport master (
      output if_pc,
      input  if_hit, if_pred_taken, if_pred_target,
      output ex_valid, ex_is_jump, ex_pc, ex_target, ex_func3,
      output ex_pred_taken, ex_pred_target,
      output carry_flag, zero_flag, negative_flag, overflow_flag,
      input  flush, redirect_pc, mispredict_count
   );

   modport slave (
      input  if_pc,
      output if_hit, if_pred_taken, if_pred_target,
      input  ex_valid, ex_is_jump, ex_pc, ex_target, ex_func3,
      input  ex_pred_taken, ex_pred_target,
      input  carry_flag, zero_flag, negative_flag, overflow_flag,
      output flush, redirect_pc, mispredict_count
   );
endinterface

// File: rtl/btb_branch_resolver.sv
// -----------------------------------------------------------------------------
// btb_branch_resolver
// Direct-mapped branch target buffer with 2-bit saturating direction counters,
// plus execute-stage branch resolution and mispredict redirect.
//
// Ports:
//   clk    : single clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : btb_branch_resolver_if.slave (lookup, resolution, redirect)
//
// Parameters:
//   ENTRIES : number of BTB entries (power of two, >= 2)
//   TAG_W   : tag width, must equal 32-2-log2(ENTRIES)
//
// Lookup is purely combinational from registered table state, so an update
// and a lookup to the same index in one cycle sees the old contents.
// -----------------------------------------------------------------------------
module btb_branch_resolver #(
   parameter int ENTRIES = 16,
   parameter int TAG_W   = 32 - 2 - $clog2(ENTRIES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   btb_branch_resolver_if.slave  bus
);
   localparam int IDX_W = $clog2(ENTRIES);

   // Counter encoding: bit[1] is the taken prediction.
   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_ST  = 2'b10,
      CTR_WT  = 2'b11
   } ctr_e;

   // ---------------------------------------------------------------- storage
   logic [ENTRIES-1:0] valid_q;
   logic [1:0]         ctr_q [ENTRIES];
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [31:0]        tgt_q [ENTRIES];

   logic               flush_q,    flush_d;
   logic [31:0]        redirect_q, redirect_d;
   logic [31:0]        count_q,    count_d;

   // ---------------------------------------------------------------- lookup
   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit;

   assign lk_idx = bus.if_pc[IDX_W+1:2];
   assign lk_tag = bus.if_pc[31:IDX_W+2];
   assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

   assign bus.if_hit         = lk_hit;
   assign bus.if_pred_taken  = lk_hit && ctr_q[lk_idx][1];
   assign bus.if_pred_target = lk_hit ? tgt_q[lk_idx] : (bus.if_pc + 32'd4);

   // ---------------------------------------------------------------- resolve
   logic        kind_ok;   // 0 for the unused func3 codes 010/011
   logic        taken;
   logic        active;
   logic        mispredict;
   logic [31:0] correct_pc;

   always_comb begin
      kind_ok = 1'b1;
      taken   = 1'b0;
      if (bus.ex_is_jump) begin
         taken = 1'b1;
      end else begin
         unique case (bus.ex_func3)
            3'b000:  taken = bus.zero_flag;                            // BEQ
            3'b001:  taken = !bus.zero_flag;                           // BNE
            3'b100:  taken = bus.negative_flag ^ bus.overflow_flag;    // BLT
            3'b101:  taken = !(bus.negative_flag ^ bus.overflow_flag); // BGE
            3'b110:  taken = !bus.carry_flag;                          // BLTU (borrow)
            3'b111:  taken = bus.carry_flag;                           // BGEU
            default: kind_ok = 1'b0;
         endcase
      end
   end

   assign active     = bus.ex_valid && kind_ok;
   assign correct_pc = taken ? bus.ex_target : (bus.ex_pc + 32'd4);
   // A taken/taken pair still mispredicts if fetch went to the wrong target.
   assign mispredict = active &&
                       ((taken != bus.ex_pred_taken) ||
                        (taken && bus.ex_pred_taken &&
                         (bus.ex_pred_target != bus.ex_target)));

   // ---------------------------------------------------------------- update
   logic [IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0] ex_tag;
   logic             ex_hit;
   logic             wr_ctr_en;
   logic [1:0]       wr_ctr;
   logic             wr_tgt_en;
   logic             alloc;

   assign ex_idx = bus.ex_pc[IDX_W+1:2];
   assign ex_tag = bus.ex_pc[31:IDX_W+2];
   assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

   function automatic logic [1:0] ctr_next(input logic [1:0] cur, input logic tk);
      logic [1:0] nxt;
      nxt = cur;
      unique case (cur)
         CTR_SNT: nxt = tk ? CTR_WNT : CTR_SNT;
         CTR_WNT: nxt = tk ? CTR_WT  : CTR_SNT;
         CTR_WT:  nxt = tk ? CTR_ST  : CTR_WNT;
         CTR_ST:  nxt = tk ? CTR_ST  : CTR_WT;
         default: nxt = cur;
      endcase
      return nxt;
   endfunction

   always_comb begin
      wr_ctr_en = 1'b0;
      wr_ctr    = CTR_SNT;
      wr_tgt_en = 1'b0;
      alloc     = 1'b0;
      if (active) begin
         if (ex_hit) begin
            wr_ctr_en = 1'b1;
            wr_ctr    = bus.ex_is_jump ? CTR_ST : ctr_next(ctr_q[ex_idx], taken);
            wr_tgt_en = taken;
         end else if (taken) begin
            // Miss and taken: replace whatever lives at this index.
            alloc     = 1'b1;
            wr_ctr_en = 1'b1;
            wr_ctr    = bus.ex_is_jump ? CTR_ST : CTR_WT;
            wr_tgt_en = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- redirect
   always_comb begin
      flush_d    = mispredict;
      redirect_d = mispredict ? correct_pc : redirect_q;
      count_d    = (mispredict && (count_q != 32'hFFFF_FFFF)) ? (count_q + 32'd1) : count_q;
   end

   assign bus.flush            = flush_q;
   assign bus.redirect_pc      = redirect_q;
   assign bus.mispredict_count = count_q;

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= '0;
         flush_q    <= 1'b0;
         redirect_q <= '0;
         count_q    <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= CTR_SNT;
         end
      end else begin
         flush_q    <= flush_d;
         redirect_q <= redirect_d;
         count_q    <= count_d;
         if (alloc)     valid_q[ex_idx] <= 1'b1;
         if (wr_ctr_en) ctr_q[ex_idx]   <= wr_ctr;
      end
   end

   // Tags and targets are qualified by valid_q, so they need no reset.
   always_ff @(posedge clk) begin
      if (alloc)     tag_q[ex_idx] <= ex_tag;
      if (wr_tgt_en) tgt_q[ex_idx] <= bus.ex_target;
   end

endmodule

// File: tb/tb_btb_branch_resolver.sv
module tb_btb_branch_resolver;

   localparam int ENTRIES = 16;
   localparam int W = 65;   // {flush, redirect_pc, mispredict_count}

   logic clk;
   logic rst_n;

   btb_branch_resolver_if bus ();

   btb_branch_resolver #(.ENTRIES(ENTRIES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // --------------------------------------------------------- clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // --------------------------------------------------------- scoreboard
   logic [W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_lookup(input string name, input logic [31:0] pc,
                               input logic hit, input logic pt, input logic [31:0] tgt);
      bus.if_pc = pc;
      #1;
      check({name, ".hit"},    {31'd0, bus.if_hit},        {31'd0, hit});
      check({name, ".ptaken"}, {31'd0, bus.if_pred_taken}, {31'd0, pt});
      check({name, ".ptgt"},   bus.if_pred_target,         tgt);
   endtask

   // pop one expected registered result and compare against the DUT
   task automatic sb_compare(input string name);
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s.sb: got empty queue, required one entry", name);
      end else begin
         e = exp_q.pop_front();
         check({name, ".flush"},    {31'd0, bus.flush},   {31'd0, e[64]});
         check({name, ".redirect"}, bus.redirect_pc,      e[63:32]);
         check({name, ".count"},    bus.mispredict_count, e[31:0]);
      end
   endtask

   // --------------------------------------------------------- driver
   typedef struct {
      string       name;
      logic        valid;
      logic        jump;
      logic [31:0] pc;
      logic [31:0] tgt;
      logic [2:0]  f3;
      logic        pt;
      logic [31:0] ptgt;
      logic [3:0]  czvn;      // {carry, zero, negative, overflow}
      logic        exp_flush;
      logic [31:0] exp_red;
      logic [31:0] exp_cnt;
      logic [31:0] look_pc;
      logic        exp_hit;
      logic        exp_pt;
      logic [31:0] exp_ptgt;
   } vec_t;

   task automatic drive_ex(input logic valid, input logic jump, input logic [31:0] pc,
                           input logic [31:0] tgt, input logic [2:0] f3, input logic pt,
                           input logic [31:0] ptgt, input logic [3:0] czvn);
      bus.ex_valid       = valid;
      bus.ex_is_jump     = jump;
      bus.ex_pc          = pc;
      bus.ex_target      = tgt;
      bus.ex_func3       = f3;
      bus.ex_pred_taken  = pt;
      bus.ex_pred_target = ptgt;
      bus.carry_flag     = czvn[3];
      bus.zero_flag      = czvn[2];
      bus.negative_flag  = czvn[1];
      bus.overflow_flag  = czvn[0];
   endtask

   vec_t vecs [14];

   initial begin
      //          name      v  j  pc            tgt          f3      pt ptgt         czvn     fl red          cnt   look          hit pt ptgt
      vecs[0]  = '{"beq_t",  1, 0, 32'h100,      32'h200,     3'b000, 0, 32'h0,      4'b0100, 1, 32'h200,     1,  32'h100,      1, 1, 32'h200};
      vecs[1]  = '{"beq_nt", 1, 0, 32'h100,      32'h200,     3'b000, 1, 32'h200,    4'b0000, 1, 32'h104,     2,  32'h100,      1, 0, 32'h200};
      vecs[2]  = '{"beq_nt2",1, 0, 32'h100,      32'h200,     3'b000, 0, 32'h0,      4'b0000, 0, 32'h104,     2,  32'h100,      1, 0, 32'h200};
      vecs[3]  = '{"bltu",   1, 0, 32'h110,      32'h500,     3'b110, 1, 32'h500,    4'b0000, 0, 32'h104,     2,  32'h110,      1, 1, 32'h500};
      vecs[4]  = '{"bge",    1, 0, 32'h120,      32'h600,     3'b101, 0, 32'h0,      4'b0011, 1, 32'h600,     3,  32'h120,      1, 1, 32'h600};
      vecs[5]  = '{"blt",    1, 0, 32'h130,      32'h700,     3'b100, 1, 32'h700,    4'b0011, 1, 32'h134,     4,  32'h130,      0, 0, 32'h134};
      vecs[6]  = '{"jal",    1, 1, 32'h40,       32'h80,      3'b000, 0, 32'h0,      4'b0000, 1, 32'h80,      5,  32'h40,       1, 1, 32'h80};
      vecs[7]  = '{"alias",  1, 1, 32'h80,       32'h300,     3'b000, 1, 32'h80,     4'b0000, 1, 32'h300,     6,  32'h40,       0, 0, 32'h44};
      vecs[8]  = '{"f3_010", 1, 0, 32'h150,      32'h900,     3'b010, 1, 32'h900,    4'b1111, 0, 32'h300,     6,  32'h150,      0, 0, 32'h154};
      vecs[9]  = '{"idle",   0, 0, 32'h160,      32'h900,     3'b000, 0, 32'h0,      4'b0100, 0, 32'h300,     6,  32'h160,      0, 0, 32'h164};
      vecs[10] = '{"bne_tgt",1, 0, 32'h110,      32'h510,     3'b001, 1, 32'h500,    4'b0000, 1, 32'h510,     7,  32'h110,      1, 1, 32'h510};
      vecs[11] = '{"bgeu_nt",1, 0, 32'h110,      32'h510,     3'b111, 1, 32'h510,    4'b0000, 1, 32'h114,     8,  32'h110,      1, 1, 32'h510};
      vecs[12] = '{"bgeu_t", 1, 0, 32'h110,      32'h510,     3'b111, 1, 32'h510,    4'b1000, 0, 32'h114,     8,  32'h110,      1, 1, 32'h510};
      vecs[13] = '{"wrap",   1, 0, 32'hFFFFFFFC, 32'h1000,    3'b001, 1, 32'h1000,   4'b0100, 1, 32'h0,       9,  32'hFFFFFFFC, 0, 0, 32'h0};

      // ---- reset
      rst_n = 1'b0;
      bus.if_pc = 32'h100;
      drive_ex(0, 0, 32'h0, 32'h0, 3'b000, 0, 32'h0, 4'b0000);
      repeat (3) @(posedge clk);
      #1;
      check("rst.flush",    {31'd0, bus.flush},   32'd0);
      check("rst.redirect", bus.redirect_pc,      32'd0);
      check("rst.count",    bus.mispredict_count, 32'd0);
      check_lookup("rst.look", 32'h100, 0, 0, 32'h104);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ---- table: one resolution per cycle, back to back
      for (int i = 0; i < 14; i++) begin
         drive_ex(vecs[i].valid, vecs[i].jump, vecs[i].pc, vecs[i].tgt, vecs[i].f3,
                  vecs[i].pt, vecs[i].ptgt, vecs[i].czvn);
         exp_q.push_back({vecs[i].exp_flush, vecs[i].exp_red, vecs[i].exp_cnt});
         @(posedge clk);
         #1;
         sb_compare(vecs[i].name);
         check_lookup({vecs[i].name, ".look"}, vecs[i].look_pc,
                      vecs[i].exp_hit, vecs[i].exp_pt, vecs[i].exp_ptgt);
      end

      // ---- same-cycle lookup and update to one index
      drive_ex(1, 0, 32'h180, 32'h900, 3'b000, 0, 32'h0, 4'b0100);
      exp_q.push_back({1'b1, 32'h900, 32'd10});
      check_lookup("same.pre", 32'h180, 0, 0, 32'h184);
      @(posedge clk);
      #1;
      sb_compare("same");
      check_lookup("same.post", 32'h180, 1, 1, 32'h900);

      // ---- reset asserted during a mispredicting update
      drive_ex(1, 1, 32'h1C0, 32'hA00, 3'b000, 0, 32'h0, 4'b0000);
      rst_n = 1'b0;
      #1;
      check("rstmid.flush_async", {31'd0, bus.flush},   32'd0);
      check("rstmid.count_async", bus.mispredict_count, 32'd0);
      @(posedge clk);
      #1;
      check("rstmid.flush",    {31'd0, bus.flush},   32'd0);
      check("rstmid.count",    bus.mispredict_count, 32'd0);
      check("rstmid.redirect", bus.redirect_pc,      32'd0);
      drive_ex(0, 0, 32'h0, 32'h0, 3'b000, 0, 32'h0, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      check_lookup("rstmid.look1", 32'h1C0, 0, 0, 32'h1C4);
      check_lookup("rstmid.look2", 32'h180, 0, 0, 32'h184);
      @(posedge clk);
      #1;
      check("rstmid.flush_after", {31'd0, bus.flush},   32'd0);
      check("rstmid.count_after", bus.mispredict_count, 32'd0);

      // ---- final report
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL sb.leftover: got %0d entries, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
